gshare_predictor: RTL

- Parametrised gshare branch predictor for the PC stage: global history register (GHR), pattern history table (PHT) of 2-bit counters, direct-mapped branch target buffer (BTB).
- Generalises the PC stage's fixed predictor: configurable history, BTB depth and address width; speculative GHR with mispredict repair; registered one-cycle lookup with stall hold.
- Lookup side is driven by the PC stage. Update side is driven by branch resolution in execute, with the same fields the PC stage already carries: is_branch / is_jump / is_taken / pht index / inst pc / target.

---
 rtl/gshare_predictor_pkg.sv | 40 ++++
 rtl/gshare_predictor_pht.sv | 41 ++++
 rtl/gshare_predictor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare branch predictor and the PC stage:
// 2-bit counter encodings, the saturating-counter update, BTB field layout
// helpers and the reset PC shared with the PC stage.
package gshare_predictor_pkg;

  // 2-bit pattern-history counter encodings
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } pht_cnt_e;

  localparam int unsigned PHT_CNT_WIDTH = 2;

  // Reset fetch address, shared with the PC stage
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

  // BTB entry layout is {valid, tag, target, is_jump}; the tag is the PC
  // above the word offset and the index bits.
  function automatic int unsigned btb_tag_width(input int unsigned addr_w,
                                                input int unsigned idx_w);
    return addr_w - idx_w - 2;
  endfunction

  function automatic int unsigned btb_entry_width(input int unsigned addr_w,
                                                  input int unsigned idx_w);
    return 1 + btb_tag_width(addr_w, idx_w) + addr_w + 1;
  endfunction

  // Saturating counter step: taken counts up to ST, not-taken down to SNT
  function automatic logic [PHT_CNT_WIDTH-1:0] cnt_next(
      input logic [PHT_CNT_WIDTH-1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? cnt : cnt + 2'd1;
    end
    return (cnt == SNT) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_predictor_pht.sv
// pht_counter_array: 2^IDX_WIDTH 2-bit saturating counters.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (counters -> WNT)
//   rd_idx_i          read index
//   rd_cnt_c          combinational counter value at rd_idx_i (pre-update)
//   upd_en_i          apply one saturating step at upd_idx_i
//   upd_idx_i         update index
//   upd_taken_i       step direction (1 = up, 0 = down)
module pht_counter_array
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IDX_WIDTH-1:0]     rd_idx_i,
  output logic [PHT_CNT_WIDTH-1:0] rd_cnt_c,
  input  logic                     upd_en_i,
  input  logic [IDX_WIDTH-1:0]     upd_idx_i,
  input  logic                     upd_taken_i
);

  localparam int unsigned DEPTH = 2 ** IDX_WIDTH;

  logic [PHT_CNT_WIDTH-1:0] cnt_q [DEPTH];

  // Counter storage; reset leaves every entry weakly not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= WNT;
      end
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= cnt_next(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

  // Read is not bypassed: a same-cycle update is seen on the next cycle
  assign rd_cnt_c = cnt_q[rd_idx_i];

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: GHR-hashed PHT of 2-bit counters plus a direct-mapped
// BTB, with a speculative GHR repaired on mispredict.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   stall              hold pred_* and the speculative GHR
//   lookup_valid/pc    fetch address from the PC stage
//   pred_*             registered prediction, one cycle after the lookup
//   upd_*              resolved control-flow instruction from execute
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH    = 32,
  parameter int unsigned            GHR_WIDTH     = 8,
  parameter int unsigned            BTB_IDX_WIDTH = 6,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC      = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  output logic [GHR_WIDTH-1:0]  pred_pht_index,
  output logic [GHR_WIDTH-1:0]  pred_ghr,
  input  logic                  upd_valid,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic [GHR_WIDTH-1:0]  upd_pht_index,
  input  logic [GHR_WIDTH-1:0]  upd_ghr
);

  localparam int unsigned TAG_WIDTH = btb_tag_width(ADDR_WIDTH, BTB_IDX_WIDTH);
  localparam int unsigned BTB_DEPTH = 2 ** BTB_IDX_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [ADDR_WIDTH-1:0] target;
    logic                  is_jump;
  } btb_entry_t;

  // Configuration sanity: width rules and a word-aligned reset PC
  always_comb begin : p_cfg_check
    assert (GHR_WIDTH >= 2 && GHR_WIDTH + 2 <= ADDR_WIDTH &&
            BTB_IDX_WIDTH + 2 < ADDR_WIDTH && RESET_PC[1:0] == 2'b00);
  end

  btb_entry_t                btb_q [BTB_DEPTH];
  logic [GHR_WIDTH-1:0]      ghr_q, ghr_d;
  logic                      pred_valid_q, pred_taken_q;
  logic [ADDR_WIDTH-1:0]     pred_target_q;
  logic [GHR_WIDTH-1:0]      pred_pht_index_q, pred_ghr_q;

  logic [GHR_WIDTH-1:0]      lk_pht_idx_c;
  logic [BTB_IDX_WIDTH-1:0]  lk_btb_idx_c, upd_btb_idx_c;
  logic [TAG_WIDTH-1:0]      lk_tag_c, upd_tag_c;
  btb_entry_t                lk_entry_c;
  logic [PHT_CNT_WIDTH-1:0]  lk_cnt_c;
  logic                      lk_hit_c, lk_taken_c;
  logic [ADDR_WIDTH-1:0]     lk_target_c;
  logic                      unused_bits;

  // Lookup indexing and prediction
  assign lk_pht_idx_c  = lookup_pc[GHR_WIDTH+1:2] ^ ghr_q;
  assign lk_btb_idx_c  = lookup_pc[BTB_IDX_WIDTH+1:2];
  assign lk_tag_c      = lookup_pc[ADDR_WIDTH-1:BTB_IDX_WIDTH+2];
  assign lk_entry_c    = btb_q[lk_btb_idx_c];
  assign lk_hit_c      = lk_entry_c.valid && (lk_entry_c.tag == lk_tag_c);
  assign lk_taken_c    = lk_hit_c && (lk_entry_c.is_jump || lk_cnt_c[1]);
  assign lk_target_c   = lk_taken_c ? lk_entry_c.target : lookup_pc + ADDR_WIDTH'(4);

  assign upd_btb_idx_c = upd_pc[BTB_IDX_WIDTH+1:2];
  assign upd_tag_c     = upd_pc[ADDR_WIDTH-1:BTB_IDX_WIDTH+2];

  // Byte offset of upd_pc and the counter's low bit carry no prediction info
  assign unused_bits   = ^{upd_pc[1:0], lk_cnt_c[0]};

  pht_counter_array #(
    .IDX_WIDTH (GHR_WIDTH)
  ) u_pht (
    .clk         (clk),
    .rst_n       (rst),
    .rd_idx_i    (lk_pht_idx_c),
    .rd_cnt_c    (lk_cnt_c),
    .upd_en_i    (upd_valid && !upd_is_jump),
    .upd_idx_i   (upd_pht_index),
    .upd_taken_i (upd_taken)
  );

  // BTB: only taken resolutions allocate or refresh an entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_q[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      btb_q[upd_btb_idx_c] <= '{valid: 1'b1, tag: upd_tag_c,
                                target: upd_target, is_jump: upd_is_jump};
    end
  end

  // Speculative GHR shift on conditional BTB hits; mispredict repair wins
  always_comb begin
    ghr_d = ghr_q;
    if (lookup_valid && !stall && lk_hit_c && !lk_entry_c.is_jump) begin
      ghr_d = {ghr_q[GHR_WIDTH-2:0], lk_taken_c};
    end
    if (upd_valid && upd_mispredict) begin
      ghr_d = upd_is_jump ? upd_ghr : {upd_ghr[GHR_WIDTH-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Registered prediction, held while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_target_q    <= '0;
      pred_pht_index_q <= '0;
      pred_ghr_q       <= '0;
    end else if (!stall) begin
      pred_valid_q     <= lookup_valid;
      pred_taken_q     <= lk_taken_c;
      pred_target_q    <= lk_target_c;
      pred_pht_index_q <= lk_pht_idx_c;
      pred_ghr_q       <= ghr_q;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign pred_target    = pred_target_q;
  assign pred_pht_index = pred_pht_index_q;
  assign pred_ghr       = pred_ghr_q;

endmodule
